// File: rtl/neural_net_seq_if.sv
`default_nettype none
//============================================================================
// Module      : neural_net_seq_if
// Description : Bundle of sample, result and weight-write signals for
//               neural_net_seq.
//               master : producer of samples / weights, consumer of results
//               slave  : the neural_net_seq block itself
//   ulaz_valid / ulaz_ready / uzorak     sample handshake and data
//   izlaz_valid / izlaz_ready / izlaz    result handshake and data
//   indikator                            sign bit of every output
//   tez_we / tez_addr / tez_data         weight/bias write port
//   Parameters must match those of the neural_net_seq instance.
// Revision    : 1.0 - initial release
//============================================================================
interface neural_net_seq_if #(
   parameter int N_IN   = 60,
   parameter int N_OUT  = 2,
   parameter int DATA_W = 16,
   parameter int ADDR_W = 10
);
   logic                       ulaz_valid;
   logic                       ulaz_ready;
   logic [N_IN*DATA_W-1:0]     uzorak;
   logic                       izlaz_valid;
   logic                       izlaz_ready;
   logic [N_OUT*DATA_W-1:0]    izlaz;
   logic [N_OUT-1:0]           indikator;
   logic                       tez_we;
   logic [ADDR_W-1:0]          tez_addr;
   logic [DATA_W-1:0]          tez_data;

   modport master (
      output ulaz_valid, uzorak, izlaz_ready, tez_we, tez_addr, tez_data,
      input  ulaz_ready, izlaz_valid, izlaz, indikator
   );

   modport slave (
      input  ulaz_valid, uzorak, izlaz_ready, tez_we, tez_addr, tez_data,
      output ulaz_ready, izlaz_valid, izlaz, indikator
   );
endinterface
`default_nettype wire

// File: rtl/neural_net_seq.sv
`default_nettype none
//============================================================================
// Module      : neural_net_seq
// Description : Time-multiplexed two-layer neural net. One signed MAC
//               evaluates every hidden neuron, then every output neuron,
//               one product per clock. Weights/biases live in a run-time
//               writable memory that is not cleared by reset.
// Ports       : clk    - clock, rising edge
//               rst_n  - asynchronous active-low reset
//               bus    - neural_net_seq_if.slave (sample in, result out,
//                        weight write port)
// Option      : NEURAL_NET_SEQ_RELU_EN - hidden activation is ReLU when
//               defined, identity otherwise. Output layer is always linear.
// Revision    : 1.0 - initial release
//============================================================================
module neural_net_seq #(
   parameter int N_IN   = 60,
   parameter int N_HID  = 5,
   parameter int N_OUT  = 2,
   parameter int DATA_W = 16,
   parameter int FRAC_W = 8,
   parameter int ADDR_W = 10
) (
   input logic          clk,
   input logic          rst_n,
   neural_net_seq_if.slave bus
);

   // Word counts of the weight map: hidden block first, output block after.
   localparam int N_HID_WORDS = N_HID * (N_IN + 1);
   localparam int N_WORDS     = N_HID_WORDS + N_OUT * (N_HID + 1);
   localparam int MEM_AW      = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
   localparam int ACC_W       = 2 * DATA_W + $clog2(N_IN + 1);
   localparam int CNT_MAX     = (N_IN > N_HID) ? N_IN : N_HID;
   localparam int CNT_W       = $clog2(CNT_MAX + 1);
   localparam int NEU_MAX     = (N_HID > N_OUT) ? N_HID : N_OUT;
   localparam int NEU_W       = $clog2(NEU_MAX + 1);

   localparam logic [ADDR_W:0]    WORDS_C   = (ADDR_W + 1)'(N_WORDS);
   localparam logic [CNT_W-1:0]   N_IN_C    = CNT_W'(N_IN);
   localparam logic [CNT_W-1:0]   N_HID_C   = CNT_W'(N_HID);
   localparam logic [NEU_W-1:0]   LAST_HID  = NEU_W'(N_HID - 1);
   localparam logic [NEU_W-1:0]   LAST_OUT  = NEU_W'(N_OUT - 1);
   localparam logic signed [ACC_W-1:0] SAT_MAX =
      {{(ACC_W - DATA_W + 1){1'b0}}, {(DATA_W - 1){1'b1}}};
   localparam logic signed [ACC_W-1:0] SAT_MIN =
      {{(ACC_W - DATA_W + 1){1'b1}}, {(DATA_W - 1){1'b0}}};

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_HID  = 2'd1;
   localparam logic [1:0] S_OUT  = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   logic [1:0]                 state_q, state_d;
   logic [CNT_W-1:0]           in_q, in_d;
   logic [NEU_W-1:0]           neu_q, neu_d;
   logic [MEM_AW-1:0]          waddr_q, waddr_d;
   logic signed [ACC_W-1:0]    acc_q, acc_d;
   logic signed [DATA_W-1:0]   sample_q [N_IN];
   logic signed [DATA_W-1:0]   sample_d [N_IN];
   logic signed [DATA_W-1:0]   hid_q [N_HID];
   logic signed [DATA_W-1:0]   hid_d [N_HID];
   logic signed [DATA_W-1:0]   res_q [N_OUT];
   logic signed [DATA_W-1:0]   res_d [N_OUT];
   logic [N_OUT*DATA_W-1:0]    izlaz_q, izlaz_d;
   logic [N_OUT-1:0]           ind_q, ind_d;

   // Weight memory: deliberately outside the reset domain.
   logic [DATA_W-1:0]          mem_q [N_WORDS];

   logic signed [DATA_W-1:0]   w_w, x_w, act_w, sat_w;
   logic signed [2*DATA_W-1:0] xe_w, we_w, prod_w;
   logic signed [ACC_W-1:0]    sum_w, shift_w;
   logic [CNT_W-1:0]           limit_w;
   logic                       mac_w, last_neu_w, wr_ok_w;

   //-------------------------------------------------------------------------
   // Datapath. The address counter walks the weight map linearly, so the
   // word it points at is always the weight (or bias) for the current cycle.
   //-------------------------------------------------------------------------
   assign w_w = mem_q[waddr_q];

   always_comb begin
      x_w = '0;
      if (state_q == S_HID) begin
         for (int k = 0; k < N_IN; k++)
            if (in_q == CNT_W'(k)) x_w = sample_q[k];
      end else begin
         for (int k = 0; k < N_HID; k++)
            if (in_q == CNT_W'(k)) x_w = hid_q[k];
      end
   end

   assign xe_w   = {{DATA_W{x_w[DATA_W-1]}}, x_w};
   assign we_w   = {{DATA_W{w_w[DATA_W-1]}}, w_w};
   assign prod_w = xe_w * we_w;

   // Bias is aligned to the product's 2*FRAC_W fraction before rescaling.
   assign sum_w   = acc_q + {{(ACC_W - DATA_W - FRAC_W){w_w[DATA_W-1]}}, w_w, {FRAC_W{1'b0}}};
   assign shift_w = sum_w >>> FRAC_W;

   always_comb begin
      if (shift_w > SAT_MAX)      sat_w = SAT_MAX[DATA_W-1:0];
      else if (shift_w < SAT_MIN) sat_w = SAT_MIN[DATA_W-1:0];
      else                        sat_w = shift_w[DATA_W-1:0];
   end

`ifdef NEURAL_NET_SEQ_RELU_EN
   assign act_w = sat_w[DATA_W-1] ? '0 : sat_w;
`else
   assign act_w = sat_w;
`endif

   assign limit_w    = (state_q == S_HID) ? N_IN_C : N_HID_C;
   assign mac_w      = (in_q < limit_w);
   assign last_neu_w = (state_q == S_HID) ? (neu_q == LAST_HID) : (neu_q == LAST_OUT);

   //-------------------------------------------------------------------------
   // Next-state logic
   //-------------------------------------------------------------------------
   always_comb begin
      state_d  = state_q;
      in_d     = in_q;
      neu_d    = neu_q;
      waddr_d  = waddr_q;
      acc_d    = acc_q;
      sample_d = sample_q;
      hid_d    = hid_q;
      res_d    = res_q;
      izlaz_d  = izlaz_q;
      ind_d    = ind_q;

      case (state_q)
         S_IDLE: begin
            if (bus.ulaz_valid) begin
               for (int k = 0; k < N_IN; k++)
                  sample_d[k] = bus.uzorak[k*DATA_W +: DATA_W];
               state_d = S_HID;
               in_d    = '0;
               neu_d   = '0;
               waddr_d = '0;
               acc_d   = '0;
            end
         end
         S_HID, S_OUT: begin
            waddr_d = waddr_q + MEM_AW'(1);
            if (mac_w) begin
               acc_d = acc_q + {{(ACC_W - 2*DATA_W){prod_w[2*DATA_W-1]}}, prod_w};
               in_d  = in_q + CNT_W'(1);
            end else begin
               // Finish cycle: the current word is this neuron's bias.
               acc_d = '0;
               in_d  = '0;
               if (state_q == S_HID) begin
                  for (int k = 0; k < N_HID; k++)
                     if (neu_q == NEU_W'(k)) hid_d[k] = act_w;
               end else begin
                  for (int k = 0; k < N_OUT; k++)
                     if (neu_q == NEU_W'(k)) res_d[k] = sat_w;
               end
               if (last_neu_w) begin
                  neu_d = '0;
                  if (state_q == S_HID) begin
                     state_d = S_OUT;
                  end else begin
                     // Results become visible all at once, on entry to DONE.
                     state_d = S_DONE;
                     waddr_d = '0;
                     for (int o = 0; o < N_OUT; o++) begin
                        if (o == N_OUT - 1) begin
                           izlaz_d[o*DATA_W +: DATA_W] = sat_w;
                           ind_d[o] = sat_w[DATA_W-1];
                        end else begin
                           izlaz_d[o*DATA_W +: DATA_W] = res_q[o];
                           ind_d[o] = res_q[o][DATA_W-1];
                        end
                     end
                  end
               end else begin
                  neu_d = neu_q + NEU_W'(1);
               end
            end
         end
         S_DONE: begin
            if (bus.izlaz_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   //-------------------------------------------------------------------------
   // State registers
   //-------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         in_q    <= '0;
         neu_q   <= '0;
         waddr_q <= '0;
         acc_q   <= '0;
         izlaz_q <= '0;
         ind_q   <= '0;
         for (int k = 0; k < N_IN; k++)  sample_q[k] <= '0;
         for (int k = 0; k < N_HID; k++) hid_q[k]    <= '0;
         for (int k = 0; k < N_OUT; k++) res_q[k]    <= '0;
      end else begin
         state_q  <= state_d;
         in_q     <= in_d;
         neu_q    <= neu_d;
         waddr_q  <= waddr_d;
         acc_q    <= acc_d;
         izlaz_q  <= izlaz_d;
         ind_q    <= ind_d;
         sample_q <= sample_d;
         hid_q    <= hid_d;
         res_q    <= res_d;
      end
   end

   // Writes are only accepted while the MAC is not reading the memory.
   assign wr_ok_w = bus.tez_we
                 && ((state_q == S_IDLE) || (state_q == S_DONE))
                 && ({1'b0, bus.tez_addr} < WORDS_C);

   always_ff @(posedge clk) begin
      if (wr_ok_w) mem_q[bus.tez_addr[MEM_AW-1:0]] <= bus.tez_data;
   end

   assign bus.ulaz_ready  = (state_q == S_IDLE);
   assign bus.izlaz_valid = (state_q == S_DONE);
   assign bus.izlaz       = izlaz_q;
   assign bus.indikator   = ind_q;

endmodule
`default_nettype wire

// File: tb/tb_neural_net_seq.sv
`default_nettype none
//============================================================================
// Module      : tb_neural_net_seq
// Description : Self-checking bench for neural_net_seq. Table of weight
//               setups and samples with known results, a reference model
//               feeding a result scoreboard, and hand-written sequences for
//               back-pressure, blocked writes and mid-run reset.
//               Honors NEURAL_NET_SEQ_RELU_EN like the design.
// Revision    : 1.0 - initial release
//============================================================================
module tb_neural_net_seq;
   localparam int N_IN = 60, N_HID = 5, N_OUT = 2, DW = 16, FW = 8, AW = 10;
   localparam int HW  = N_HID * (N_IN + 1);
   localparam int NW  = HW + N_OUT * (N_HID + 1);
   localparam int LAT = NW;

   typedef logic [N_IN*DW-1:0]  samp_t;
   typedef logic [N_OUT*DW-1:0] res_t;
   typedef struct packed { res_t izl; logic [N_OUT-1:0] ind; } exp_t;
   typedef struct {
      int            setup;
      logic [DW-1:0] x0;
      logic [DW-1:0] xr;
      res_t          izl;
      logic [N_OUT-1:0] ind;
      string         name;
   } vec_t;

`ifdef NEURAL_NET_SEQ_RELU_EN
   localparam res_t          NEG_IZL = {16'h0000, 16'h0000};
   localparam logic [1:0]    NEG_IND = 2'b00;
`else
   localparam res_t          NEG_IZL = {16'h0000, 16'hFE00};
   localparam logic [1:0]    NEG_IND = 2'b01;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   neural_net_seq_if #(.N_IN(N_IN), .N_OUT(N_OUT), .DATA_W(DW), .ADDR_W(AW)) bus ();

   neural_net_seq #(
      .N_IN(N_IN), .N_HID(N_HID), .N_OUT(N_OUT),
      .DATA_W(DW), .FRAC_W(FW), .ADDR_W(AW)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   logic signed [DW-1:0] wm [NW];
   exp_t sbq [$];
   int errors = 0;
   int checks = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
      checks++;
      if (act !== want) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, want);
      end
   endtask

   function automatic longint sat16(input longint v);
      if (v > 32767)  return 32767;
      if (v < -32768) return -32768;
      return v;
   endfunction

   function automatic exp_t model(input samp_t s);
      exp_t   e;
      longint acc, r;
      longint hid [N_HID];
      for (int h = 0; h < N_HID; h++) begin
         acc = 0;
         for (int i = 0; i < N_IN; i++)
            acc += longint'($signed(s[i*DW +: DW])) * longint'(wm[h*(N_IN+1)+i]);
         acc += longint'(wm[h*(N_IN+1)+N_IN]) * 256;
         hid[h] = sat16(acc >>> FW);
`ifdef NEURAL_NET_SEQ_RELU_EN
         if (hid[h] < 0) hid[h] = 0;
`endif
      end
      e = '0;
      for (int o = 0; o < N_OUT; o++) begin
         acc = 0;
         for (int k = 0; k < N_HID; k++)
            acc += hid[k] * longint'(wm[HW+o*(N_HID+1)+k]);
         acc += longint'(wm[HW+o*(N_HID+1)+N_HID]) * 256;
         r = sat16(acc >>> FW);
         e.izl[o*DW +: DW] = r[DW-1:0];
         e.ind[o] = (r < 0);
      end
      return e;
   endfunction

   function automatic samp_t mk(input logic [DW-1:0] x0, input logic [DW-1:0] xr);
      samp_t s;
      for (int i = 0; i < N_IN; i++) s[i*DW +: DW] = (i == 0) ? x0 : xr;
      return s;
   endfunction

   // Single write; caller guarantees the DUT is in IDLE.
   task automatic wr(input int a, input logic [DW-1:0] d);
      bus.tez_we = 1'b1; bus.tez_addr = AW'(a); bus.tez_data = d;
      @(posedge clk); #1;
      bus.tez_we = 1'b0;
      if (a < NW) wm[a] = d;
   endtask

   task automatic load_setup(input int st);
      logic [DW-1:0] v;
      for (int a = 0; a < NW; a++) begin
         v = '0;
         case (st)
            0: if (a == HW + N_HID) v = 16'hFF00;
               else if (a == HW + (N_HID+1) + N_HID) v = 16'h0100;
            1: if (a == 0 || a == HW) v = 16'h0100;
            2: if (a < HW && (a % (N_IN+1)) != N_IN) v = 16'h7FFF;
               else if (a == HW) v = 16'h0100;
            default: begin
               v = 16'($urandom_range(0, 511));
               v = v - 16'd256;
            end
         endcase
         wr(a, v);
      end
   endtask

   // Offer one sample from IDLE, wait for its result and score it.
   task automatic run(input samp_t s, output res_t got);
      exp_t e;
      res_t prev;
      bit   chg;
      int   lat;
      got = '0;
      bus.uzorak = s; bus.ulaz_valid = 1'b1;
      chk("accept_ready", 64'(bus.ulaz_ready), 64'd1);
      @(posedge clk); #1;
      bus.ulaz_valid = 1'b0;
      bus.uzorak = ~s;
      sbq.push_back(model(s));
      chk("busy", 64'(bus.ulaz_ready), 64'd0);
      prev = bus.izlaz; chg = 0; lat = 0;
      while (!bus.izlaz_valid && lat < 2000) begin
         if (bus.izlaz !== prev) chg = 1;
         @(posedge clk); #1;
         lat++;
      end
      if (!bus.izlaz_valid) begin
         checks++; errors++;
         $display("FAIL run_timeout: got no izlaz_valid after %0d cycles, expected %0d", lat, LAT);
         void'(sbq.pop_front());
         return;
      end
      e = sbq.pop_front();
      chk("izlaz", 64'(bus.izlaz), 64'(e.izl));
      chk("indikator", 64'(bus.indikator), 64'(e.ind));
      chk("latency", 64'(lat), 64'(LAT));
      chk("izlaz_retained", 64'(chg), 64'd0);
      got = bus.izlaz;
   endtask

   task automatic consume();
      bus.izlaz_ready = 1'b1;
      @(posedge clk); #1;
      bus.izlaz_ready = 1'b0;
      chk("consume", 64'({bus.izlaz_valid, bus.ulaz_ready}), 64'b01);
   endtask

   initial begin
      vec_t  tv [4];
      res_t  r1, r2;
      res_t  held;
      samp_t s;
      int    cur;

      tv[0] = '{0, 16'h0000, 16'h0000, {16'h0100, 16'hFF00}, 2'b01, "bias_only"};
      tv[1] = '{1, 16'h0200, 16'h0000, {16'h0000, 16'h0200}, 2'b00, "pos_pass"};
      tv[2] = '{1, 16'hFE00, 16'h0000, NEG_IZL,              NEG_IND, "neg_pass"};
      tv[3] = '{2, 16'h7FFF, 16'h7FFF, {16'h0000, 16'h7FFF}, 2'b00, "hid_sat"};

      bus.ulaz_valid = 1'b0; bus.uzorak = '0; bus.izlaz_ready = 1'b0;
      bus.tez_we = 1'b0; bus.tez_addr = '0; bus.tez_data = '0;
      for (int a = 0; a < NW; a++) wm[a] = '0;

      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_ulaz_ready", 64'(bus.ulaz_ready), 64'd1);
      chk("rst_izlaz_valid", 64'(bus.izlaz_valid), 64'd0);
      chk("rst_izlaz", 64'(bus.izlaz), 64'd0);
      chk("rst_indikator", 64'(bus.indikator), 64'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Table-driven vectors
      cur = -1;
      for (int v = 0; v < 4; v++) begin
         if (tv[v].setup != cur) begin
            load_setup(tv[v].setup);
            cur = tv[v].setup;
         end
         run(mk(tv[v].x0, tv[v].xr), r1);
         chk({"tbl_izlaz_", tv[v].name}, 64'(r1), 64'(tv[v].izl));
         chk({"tbl_ind_", tv[v].name}, 64'(bus.indikator), 64'(tv[v].ind));
         consume();
      end

      // Random weights and samples, scored by the model only
      load_setup(3);
      for (int n = 0; n < 2; n++) begin
         for (int i = 0; i < N_IN; i++) s[i*DW +: DW] = 16'($urandom_range(0, 255)) - 16'd128;
         run(s, r1);
         consume();
      end

      // Back-pressure in DONE with a competing sample offered
      load_setup(1);
      s = mk(16'h0200, 16'h0000);
      run(s, r1);
      held = bus.izlaz;
      bus.uzorak = mk(16'h0100, 16'h0000);
      bus.ulaz_valid = 1'b1;
      for (int c = 0; c < 20; c++) begin
         @(posedge clk); #1;
         chk("hold_izlaz", 64'(bus.izlaz), 64'(held));
         chk("hold_flags", 64'({bus.ulaz_ready, bus.izlaz_valid}), 64'b01);
      end
      bus.ulaz_valid = 1'b0;
      consume();
      @(posedge clk); #1;
      chk("no_accept", 64'(bus.ulaz_ready), 64'd1);

      // Writes during HID must be ignored
      fork
         run(s, r1);
         begin
            repeat (10) @(posedge clk);
            #2;
            bus.tez_we = 1'b1; bus.tez_addr = AW'(HW); bus.tez_data = 16'h0300;
            repeat (5) @(posedge clk);
            #2;
            bus.tez_addr = '0;
            repeat (3) @(posedge clk);
            #2;
            bus.tez_we = 1'b0;
         end
      join
      consume();
      run(s, r2);
      chk("rerun_same", 64'(r2), 64'(r1));
      consume();

      // Out-of-range addresses must not alias onto real weights
      wr(512, 16'h7FFF);
      wr(512 + HW, 16'h7FFF);
      wr(NW, 16'h7FFF);
      run(s, r2);
      chk("oor_write_ignored", 64'(r2), 64'(r1));
      consume();

      // Reset at cycle 100 of a computation
      bus.uzorak = s; bus.ulaz_valid = 1'b1;
      @(posedge clk); #1;
      bus.ulaz_valid = 1'b0;
      repeat (99) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk("midrst_izlaz", 64'(bus.izlaz), 64'd0);
      chk("midrst_indikator", 64'(bus.indikator), 64'd0);
      chk("midrst_flags", 64'({bus.ulaz_ready, bus.izlaz_valid}), 64'b10);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      run(s, r2);
      chk("midrst_rerun", 64'(r2), 64'(r1));
      consume();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
`default_nettype wire
